// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generation stage: RV32I opcodes, link-register
// indices and immediate extraction helpers used by static next-PC prediction.
package pc_gen_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack. Pushing when full silently overwrites the
// oldest entry; popping when empty is ignored. The top entry is read combinationally.
module pc_gen_ras #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     replace,
  input  logic [31:0]              wdata,
  output logic [31:0]              top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      entry_reg [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;
  assign top   = entry_reg[ptr_reg];

  // A push writes one slot above the current top; replace rewrites the top in place.
  assign wr_idx = push ? ptr_reg + 1'b1 : ptr_reg;
  assign wr_en  = push | replace;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (srst) begin
          entry_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
          entry_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    if (push) begin
      ptr_next = ptr_reg + 1'b1;
      if (!full) begin
        count_next = count_reg + 1'b1;
      end
    end else if (pop && !empty) begin
      ptr_next   = ptr_reg - 1'b1;
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with same-cycle static prediction (JAL taken, backward
// branches taken, returns via RAS); execute redirects and stalls override it.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] inst,
  input  logic        is_jump,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_branch,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;
  logic [31:0]      pc_plus4;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic             rd_link;
  logic             rs1_link;
  logic             advance;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;
  logic [31:0]      ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;

  assign pc       = pc_reg;
  assign pc_plus4 = pc_reg + 32'd4;
  assign rd       = inst[11:7];
  assign rs1      = inst[19:15];
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);
  assign advance  = !rst && !redirect_valid && !stall;

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    if (is_jump) begin
      if (is_jal) begin
        pred_taken  = 1'b1;
        pred_target = pc_reg + j_imm(inst);
        ras_push    = rd_link;
      end else if (is_jalr) begin
        if (rd_link && rs1_link) begin
          // Co-routine swap needs a valid top; with an empty stack it degrades to a plain call.
          if ((rd == rs1) || ras_empty) begin
            ras_push = 1'b1;
          end else begin
            pred_taken  = 1'b1;
            pred_target = ras_top;
            ras_replace = 1'b1;
          end
        end else if (rs1_link) begin
          ras_pop = 1'b1;
          if (!ras_empty) begin
            pred_taken  = 1'b1;
            pred_target = ras_top;
          end
        end else if (rd_link) begin
          ras_push = 1'b1;
        end
      end else if (is_branch) begin
        pred_taken = inst[31];
        if (inst[31]) begin
          pred_target = pc_reg + b_imm(inst);
        end
      end
    end
  end

  always_comb begin
    pc_next = pc_reg;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (!stall) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    pc_reg <= pc_next;
  end

  pc_gen_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .srst    (rst),
    .push    (ras_push & advance),
    .pop     (ras_pop & advance),
    .replace (ras_replace & advance),
    .wdata   (pc_plus4),
    .top     (ras_top),
    .count   (ras_count),
    .empty   (ras_empty),
    .full    (ras_full)
  );

  // Decode flags from fetch must agree with the opcode they claim to describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ras_full && ras_empty) && (ras_count <= CNT_W'(RAS_DEPTH)));
      if (is_jump) begin
        assert (!is_jal || (inst[6:0] == OP_JAL));
        assert (!is_jalr || (inst[6:0] == OP_JALR));
        assert (!is_branch || (inst[6:0] == OP_BRANCH));
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: the stimulus process plays fetch and queues the
// expected pc/prediction per cycle; a monitor pops and compares on the falling edge.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam logic [31:0] JAL_64   = 32'h0400_00EF;  // jal x1,+64
  localparam logic [31:0] JAL_16   = 32'h0100_00EF;  // jal x1,+16
  localparam logic [31:0] RET      = 32'h0000_8067;  // jalr x0,0(x1)
  localparam logic [31:0] BEQ_BACK = 32'hFE00_0EE3;  // beq x0,x0,-4
  localparam logic [31:0] BEQ_FWD  = 32'h0000_0463;  // beq x0,x0,+8

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] inst = NOP_INST;
  logic        is_jump = 1'b0;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic        is_branch = 1'b0;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst           (inst),
    .is_jump        (is_jump),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .is_branch      (is_branch),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // One cycle of stimulus: drive inputs just after the edge, queue what the DUT must show this cycle.
  task automatic run(input logic r, input logic [31:0] i, input logic s, input logic rv,
                     input logic [31:0] rp, input logic [31:0] epc, input logic et,
                     input logic [31:0] etg, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    inst           = i;
    is_jal         = (i[6:0] == OP_JAL);
    is_jalr        = (i[6:0] == OP_JALR);
    is_branch      = (i[6:0] == OP_BRANCH);
    is_jump        = is_jal | is_jalr | is_branch;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    e.pc     = epc;
    e.taken  = et;
    e.target = etg;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (pc !== e.pc) begin
          errors++;
          $display("FAIL %s pc: got %h expected %h", t, pc, e.pc);
        end
        checks++;
        if (pred_taken !== e.taken) begin
          errors++;
          $display("FAIL %s pred_taken: got %b expected %b", t, pred_taken, e.taken);
        end
        checks++;
        if (pred_target !== e.target) begin
          errors++;
          $display("FAIL %s pred_target: got %h expected %h", t, pred_target, e.target);
        end
        $display("%-16s pc=%h taken=%b target=%h", t, pc, pred_taken, pred_target);
      end
    end
  end

  initial begin : stimulus
    //  rst  inst      stl rv  rpc            exp pc        tk    target
    run(1'b1, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0000, 1'b0, 32'h0000_0004, "reset0");
    run(1'b1, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0000, 1'b0, 32'h0000_0004, "reset1");
    run(1'b0, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0000, 1'b0, 32'h0000_0004, "seq_0");
    run(1'b0, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0004, 1'b0, 32'h0000_0008, "seq_4");
    run(1'b0, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0008, 1'b0, 32'h0000_000C, "seq_8");
    run(1'b0, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_000C, 1'b0, 32'h0000_0010, "seq_c");
    run(1'b0, JAL_64,   1'b0, 1'b0, 32'h0,   32'h0000_0010, 1'b1, 32'h0000_0050, "jal_call");
    run(1'b0, RET,      1'b0, 1'b0, 32'h0,   32'h0000_0050, 1'b1, 32'h0000_0014, "return");
    run(1'b0, NOP_INST, 1'b0, 1'b1, 32'h40,  32'h0000_0014, 1'b0, 32'h0000_0018, "redir_40");
    run(1'b0, BEQ_BACK, 1'b0, 1'b0, 32'h0,   32'h0000_0040, 1'b1, 32'h0000_003C, "beq_back");
    run(1'b0, NOP_INST, 1'b0, 1'b1, 32'h40,  32'h0000_003C, 1'b0, 32'h0000_0040, "redir_40b");
    run(1'b0, BEQ_FWD,  1'b0, 1'b0, 32'h0,   32'h0000_0040, 1'b0, 32'h0000_0044, "beq_fwd");
    run(1'b0, NOP_INST, 1'b1, 1'b1, 32'h200, 32'h0000_0044, 1'b0, 32'h0000_0048, "stall_redir");
    run(1'b0, NOP_INST, 1'b1, 1'b0, 32'h0,   32'h0000_0200, 1'b0, 32'h0000_0204, "stall_1");
    run(1'b0, NOP_INST, 1'b1, 1'b0, 32'h0,   32'h0000_0200, 1'b0, 32'h0000_0204, "stall_2");
    run(1'b0, NOP_INST, 1'b1, 1'b0, 32'h0,   32'h0000_0200, 1'b0, 32'h0000_0204, "stall_3");
    run(1'b0, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0200, 1'b0, 32'h0000_0204, "resume");
    run(1'b0, RET,      1'b0, 1'b0, 32'h0,   32'h0000_0204, 1'b0, 32'h0000_0208, "ret_empty");
    run(1'b0, JAL_16,   1'b0, 1'b0, 32'h0,   32'h0000_0208, 1'b1, 32'h0000_0218, "call_1");
    run(1'b0, JAL_16,   1'b0, 1'b0, 32'h0,   32'h0000_0218, 1'b1, 32'h0000_0228, "call_2");
    run(1'b0, JAL_16,   1'b0, 1'b0, 32'h0,   32'h0000_0228, 1'b1, 32'h0000_0238, "call_3");
    run(1'b0, JAL_16,   1'b0, 1'b0, 32'h0,   32'h0000_0238, 1'b1, 32'h0000_0248, "call_4");
    run(1'b0, JAL_16,   1'b0, 1'b0, 32'h0,   32'h0000_0248, 1'b1, 32'h0000_0258, "call_5_full");
    run(1'b0, RET,      1'b0, 1'b0, 32'h0,   32'h0000_0258, 1'b1, 32'h0000_024C, "ret_1");
    run(1'b0, RET,      1'b0, 1'b0, 32'h0,   32'h0000_024C, 1'b1, 32'h0000_023C, "ret_2");
    run(1'b0, RET,      1'b0, 1'b0, 32'h0,   32'h0000_023C, 1'b1, 32'h0000_022C, "ret_3");
    run(1'b0, RET,      1'b0, 1'b0, 32'h0,   32'h0000_022C, 1'b1, 32'h0000_021C, "ret_4");
    run(1'b0, RET,      1'b0, 1'b0, 32'h0,   32'h0000_021C, 1'b0, 32'h0000_0220, "ret_5_under");
    run(1'b0, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0220, 1'b0, 32'h0000_0224, "after_under");
    run(1'b1, NOP_INST, 1'b1, 1'b1, 32'h300, 32'h0000_0224, 1'b0, 32'h0000_0228, "rst_wins");
    run(1'b0, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0000, 1'b0, 32'h0000_0004, "post_rst_0");
    run(1'b0, NOP_INST, 1'b0, 1'b0, 32'h0,   32'h0000_0004, 1'b0, 32'h0000_0008, "post_rst_4");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage sitting directly upstream of `fetch`. It owns the architectural fetch PC register and drives `fetch`'s `pc` input. It consumes `fetch`'s same-cycle instruction and jump-class flags to predict the next PC statically, using a small return-address stack (RAS) for returns. Execute-stage redirects and pipeline stalls override the prediction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `RAS_DEPTH`, default 4: number of RAS entries; must be a power of 2, at least 2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  hold PC and RAS this cycle.
- `redirect_valid`  in  1  execute-stage correction.
- `redirect_pc`  in  32  corrected target.
- `inst`  in  32  instruction at current `pc`, from `fetch`, same cycle.
- `is_jump`, `is_jal`, `is_jalr`, `is_branch`  in  1 each  decode flags from `fetch`; the last three are meaningful only when `is_jump`=1.
- `pc`  out  32  registered fetch PC.
- `pred_taken`  out  1  combinational; current instruction predicted taken.
- `pred_target`  out  32  combinational; predicted next PC (pc+4 when not taken).

## Operation
- The following prediction cases apply when `is_jump`=1. Immediates are sign-extended per RV32I; all adds are mod 2^32.
  - JAL: taken. Target = pc + J-imm (bits 31,19:12,20,30:21, LSB 0).
  - Branch: taken iff inst[31]=1 (backward). Target = pc + B-imm (bits 31,7,30:25,11:8, LSB 0). Otherwise pc+4.
  - JALR return: rs1 ∈ {x1,x5} and RAS non-empty gives taken, with target = RAS top. Otherwise not taken (pc+4); execute redirects.
- The following RAS rules apply. A register is a link register if it is x1 or x5.
  - Push pc+4 on JAL or JALR with rd = link register.
  - Pop on JALR with rs1 = link register, rd not a link register.
  - JALR with both rd and rs1 link registers and rd≠rs1: target = top, then top is overwritten with pc+4; count unchanged.
  - JALR with rd=rs1, both link registers: push only (no pop), not predicted.
  - Push when full overwrites the oldest entry; count saturates at `RAS_DEPTH`.
  - Pop when empty: no prediction, count stays 0.
- Next-PC priority, highest first:
  1. `rst` loads `RESET_PC`, clears the RAS (count=0, pointer=0).
  2. `redirect_valid` loads `redirect_pc`. RAS is unchanged, and is not repaired.
  3. `stall` holds PC and RAS.
  4. Otherwise PC loads `pred_target` and RAS updates as above.
- Updates to the RAS occur only in case 4.
- When `is_jump`=0, `pred_taken`=0 and `pred_target`=pc+4.

## Timing
- The `fetch` instruction read is combinational from `pc`. Prediction is computed in the same cycle, and `pc` updates on the next rising edge, so a taken prediction has zero bubbles.
- Redirect takes effect on the next edge. The instruction fetched at `redirect_pc` appears one cycle after `redirect_valid`.
- Reset values: `pc`=`RESET_PC`; `pred_taken`/`pred_target` follow combinationally from the reset PC's instruction.
- A reset asserted mid-operation wins over redirect and stall on the same edge.
- `stall` together with `redirect_valid` is not a hold: the redirect applies.

## Structure
- The shared package holds the opcode constants (OP_JAL 7'b1101111, OP_JALR 7'b1100111, OP_BRANCH 7'b1100011), the link-register indices (x1, x5), and the functions for J-imm and B-imm extraction.
- One natural sub-module is `ras`: a circular stack with push, pop, and replace-top ports, and count/empty/full outputs, parameterized by `RAS_DEPTH`.
- `pc_gen` itself contains the PC register, prediction mux, and priority logic.

## Test plan
- Reset and sequential flow: hold `rst` for 2 cycles with NOPs (32'h00000013). Required: `pc` = 0, 4, 8, 12 on successive cycles, and `pred_taken`=0.
- JAL call: at pc=0x10, `inst`=32'h0400_00EF (jal x1,+64). Required: `pred_taken`=1, `pred_target`=0x50, next `pc`=0x50, RAS count 1 with top 0x14.
- Return: following the call, at 0x50 `inst`=32'h0000_8067 (jalr x0,0(x1)). Required: `pred_target`=0x14, next `pc`=0x14, RAS count 0.
- Backward branch: at pc=0x40, `inst`=32'hFE00_0EE3 (beq x0,x0,-4). Required: next `pc`=0x3C. Forward branch beq x0,x0,+8 at 0x40 gives next `pc`=0x44.
- Redirect and stall priority: `stall`=1, `redirect_valid`=1, `redirect_pc`=0x200 in the same cycle. Required: next `pc`=0x200. `stall` alone holds `pc` for 3 cycles.
- RAS overflow and underflow: 5 nested JAL x1 calls with `RAS_DEPTH`=4. Required: 4 returns predict the 4 newest return addresses, and the 5th return predicts pc+4 with count 0.
